// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: FSM state encoding,
// byte lane width, and the address range helper used by both channels.
package dmem_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // True when any address bit at or above position 'hi' is set.
  function automatic logic addr_oor(input logic [31:0] addr, input int unsigned hi);
    return (addr >> hi) != 32'd0;
  endfunction

endpackage

// File: rtl/dmem_ctrl_array.sv
// Word storage for dmem_ctrl: byte-enabled synchronous write and a
// registered (synchronous) read. A read and write to the same word in one
// cycle returns the pre-write contents.
module dmem_ctrl_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W/BYTE_W-1:0]   be,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       re,
  input  logic [ADDR_W-1:0]          raddr,
  output logic [DATA_W-1:0]          rdata
);

  localparam int BYTES = DATA_W / BYTE_W;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write: only lanes with their enable set are updated.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BYTES; i++) begin
        if (be[i]) begin
          mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // Registered read; the output holds between reads.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: clears the array after reset (INIT), then serves
// one read and one write channel per cycle (RUN) with range checking and a
// 1- or 2-cycle read latency.
// Optional macro DMEM_CTRL_BYPASS_EN: a same-word read and write in one
// cycle return the merged (write-first) word instead of the old contents.
//
// Handshake: in RUN, ready=1 and any cycle with rd_valid/wr_valid high is an
// accepted request (no backpressure beyond INIT); rd_rsp_valid pulses for one
// cycle exactly RD_LAT cycles after each accepted read, in request order.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  input  logic [31:0]               wr_addr,
  input  logic [DATA_W/BYTE_W-1:0]  wr_be,
  input  logic [DATA_W-1:0]         wr_wdata,
  input  logic                      rd_valid,
  input  logic [31:0]               rd_addr,
  output logic                      ready,
  output logic                      init_busy,
  output logic                      rd_rsp_valid,
  output logic [DATA_W-1:0]         rd_rdata,
  output logic                      rd_err,
  output logic                      wr_err,
  output logic                      fsm_state
);

  localparam int BYTES = DATA_W / BYTE_W;
  localparam int OFF   = $clog2(BYTES);
  localparam int HI    = ADDR_W + OFF;
  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nx;

  logic              wr_oor, rd_oor, wr_acc, rd_acc;
  logic [ADDR_W-1:0] wr_idx, rd_idx;

  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [BYTES-1:0]  arr_be;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  logic              v1, err1;
  logic [DATA_W-1:0] data1, resp1;
  logic              out_v, out_err;
  logic [DATA_W-1:0] out_data, last_q;
  logic              wr_err_q;

  assign init_busy = (state == INIT);
  assign ready     = ~init_busy;
  assign fsm_state = state;

  assign wr_oor = addr_oor(wr_addr, HI);
  assign rd_oor = addr_oor(rd_addr, HI);
  assign wr_idx = wr_addr[HI-1:OFF];
  assign rd_idx = rd_addr[HI-1:OFF];
  assign wr_acc = ~rst & (state == RUN) & wr_valid;
  assign rd_acc = ~rst & (state == RUN) & rd_valid;

  // FSM state and clear counter; reset restarts the clear from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_cnt_nx;
    end
  end

  // Next state: walk every word in INIT, then settle in RUN.
  always_comb begin
    state_nx   = state;
    clr_cnt_nx = clr_cnt;
    case (state)
      INIT: begin
        clr_cnt_nx = clr_cnt + 1'b1;
        if (clr_cnt == LAST) begin
          state_nx = RUN;
        end
      end
      default: ;
    endcase
  end

  // Array write port: zero-fill during INIT, user writes in range during RUN.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = wr_idx;
    arr_be    = wr_be;
    arr_wdata = wr_wdata;
    if (state == INIT) begin
      arr_we    = ~rst;
      arr_waddr = clr_cnt;
      arr_be    = '1;
      arr_wdata = '0;
    end else begin
      arr_we = wr_acc & ~wr_oor;
    end
  end

  dmem_ctrl_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .be    (arr_be),
    .wdata (arr_wdata),
    .re    (rd_acc & ~rd_oor),
    .raddr (rd_idx),
    .rdata (arr_rdata)
  );

  // First read stage: tracks the array read issued on the previous edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      err1 <= 1'b0;
    end else begin
      v1   <= rd_acc;
      err1 <= rd_oor;
    end
  end

`ifdef DMEM_CTRL_BYPASS_EN
  logic              byp1;
  logic [BYTES-1:0]  byp_be1;
  logic [DATA_W-1:0] byp_wdata1;

  // Capture a same-word write that collided with the accepted read.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp1 <= 1'b0;
    end else begin
      byp1 <= rd_acc & wr_acc & ~rd_oor & ~wr_oor & (rd_idx == wr_idx);
    end
    byp_be1    <= wr_be;
    byp_wdata1 <= wr_wdata;
  end

  // Merge the colliding write's enabled bytes over the old word.
  always_comb begin
    data1 = arr_rdata;
    for (int i = 0; i < BYTES; i++) begin
      if (byp1 && byp_be1[i]) begin
        data1[i*BYTE_W +: BYTE_W] = byp_wdata1[i*BYTE_W +: BYTE_W];
      end
    end
  end
`else
  assign data1 = arr_rdata;
`endif

  assign resp1 = err1 ? '0 : data1;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              v2, err2;
      logic [DATA_W-1:0] d2;

      // Second read stage for the two-cycle latency build.
      always_ff @(posedge clk) begin
        if (rst) begin
          v2   <= 1'b0;
          err2 <= 1'b0;
          d2   <= '0;
        end else begin
          v2   <= v1;
          err2 <= err1;
          if (v1) begin
            d2 <= resp1;
          end
        end
      end

      assign out_v    = v2;
      assign out_err  = err2;
      assign out_data = d2;
    end else begin : g_lat1
      assign out_v    = v1;
      assign out_err  = err1;
      assign out_data = resp1;
    end
  endgenerate

  // Remember the last delivered word so rd_rdata holds between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= '0;
    end else if (out_v) begin
      last_q <= out_data;
    end
  end

  // One-cycle error pulse for an accepted out-of-range write.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_acc & wr_oor;
    end
  end

  assign rd_rsp_valid = out_v;
  assign rd_err       = out_v & out_err;
  assign rd_rdata     = out_v ? out_data : last_q;
  assign wr_err       = wr_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Testbench for dmem_ctrl: one RD_LAT=1 and one RD_LAT=2 instance share the
// same stimulus; each has its own expected-response queue.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid, rd_valid;
  logic [31:0] wr_addr, rd_addr, wr_wdata;
  logic [3:0]  wr_be;

  logic        ready_a, init_busy_a, rsp_v_a, rd_err_a, wr_err_a, st_a;
  logic [31:0] rdata_a;
  logic        ready_b, init_busy_b, rsp_v_b, rd_err_b, wr_err_b, st_b;
  logic [31:0] rdata_b;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          running = 0;
  bit          mon_en = 0;

  logic [32:0] exp_qa[$];
  logic [32:0] exp_qb[$];
  int          due_qa[$];
  int          due_qb[$];
  int          werr_q[$];
  logic [31:0] last_a, last_b;
  logic [31:0] model [256];
  logic [32:0] e_a, e_b;
  int          d_a, d_b;

  typedef struct {
    bit          w;
    logic [31:0] wa;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          r;
    logic [31:0] ra;
    logic [32:0] exp;
  } vec_t;
  vec_t tbl[$];

  dmem_ctrl #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_wdata(wr_wdata), .rd_valid(rd_valid), .rd_addr(rd_addr), .ready(ready_a),
    .init_busy(init_busy_a), .rd_rsp_valid(rsp_v_a), .rd_rdata(rdata_a),
    .rd_err(rd_err_a), .wr_err(wr_err_a), .fsm_state(st_a)
  );

  dmem_ctrl #(.ADDR_W(8), .DATA_W(32), .RD_LAT(2)) u_dut_b (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_be(wr_be),
    .wr_wdata(wr_wdata), .rd_valid(rd_valid), .rd_addr(rd_addr), .ready(ready_b),
    .init_busy(init_busy_b), .rd_rsp_valid(rsp_v_b), .rd_rdata(rdata_b),
    .rd_err(rd_err_b), .wr_err(wr_err_b), .fsm_state(st_b)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit oor(input logic [31:0] a);
    return a[31:10] != 22'd0;
  endfunction

  // Expected {err, data} of a read, given the write issued in the same cycle.
  function automatic logic [32:0] model_expect(input logic [31:0] ra, input bit w,
                                               input logic [31:0] wa, input logic [3:0] be,
                                               input logic [31:0] wd);
    logic [31:0] d;
    if (oor(ra)) return {1'b1, 32'h0};
    d = model[ra[9:2]];
`ifdef DMEM_CTRL_BYPASS_EN
    if (w && !oor(wa) && wa[9:2] == ra[9:2]) begin
      for (int i = 0; i < 4; i++) if (be[i]) d[i*8 +: 8] = wd[i*8 +: 8];
    end
`endif
    return {1'b0, d};
  endfunction

  task automatic model_write(input logic [31:0] wa, input logic [3:0] be, input logic [31:0] wd);
    if (!oor(wa)) begin
      for (int i = 0; i < 4; i++) if (be[i]) model[wa[9:2]][i*8 +: 8] = wd[i*8 +: 8];
    end
  endtask

  // Driver: present one cycle of requests and record what they should produce.
  task automatic drive(input bit w, input logic [31:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input bit r, input logic [31:0] ra,
                       input logic [32:0] exp);
    @(posedge clk); #1;
    wr_valid = w; wr_addr = wa; wr_be = be; wr_wdata = wd;
    rd_valid = r; rd_addr = ra;
    if (running) begin
      if (r) begin
        exp_qa.push_back(exp); due_qa.push_back(cyc + 1);
        exp_qb.push_back(exp); due_qb.push_back(cyc + 2);
      end
      if (w && oor(wa)) werr_q.push_back(cyc + 1);
      if (w) model_write(wa, be, wd);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr_valid = 1'b0; rd_valid = 1'b0;
    end
  endtask

  // Reset for one edge; requests presented alongside must have no effect.
  task automatic do_reset(input int exp_b_pending);
    @(posedge clk); #1;
    rst = 1'b1; running = 0;
    wr_valid = 1'b1; wr_addr = 32'h400; wr_be = 4'hF; wr_wdata = 32'hDEADBEEF;
    rd_valid = 1'b1; rd_addr = 32'h404;
    @(posedge clk); #1;
    check("flush_a_pending", exp_qa.size(), 0);
    check("flush_b_pending", exp_qb.size(), exp_b_pending);
    exp_qa.delete(); due_qa.delete(); exp_qb.delete(); due_qb.delete(); werr_q.delete();
    last_a = '0; last_b = '0;
    mon_en = 1;
    check("rst_rsp_v_a", rsp_v_a, 0);   check("rst_rsp_v_b", rsp_v_b, 0);
    check("rst_rdata_a", rdata_a, 0);   check("rst_rdata_b", rdata_b, 0);
    check("rst_rd_err_a", rd_err_a, 0); check("rst_rd_err_b", rd_err_b, 0);
    check("rst_wr_err_a", wr_err_a, 0); check("rst_wr_err_b", wr_err_b, 0);
    check("rst_busy_a", init_busy_a, 1); check("rst_busy_b", init_busy_b, 1);
    check("rst_ready_a", ready_a, 0);   check("rst_state_a", st_a, 0);
    rst = 1'b0;
  endtask

  // Count the clear sequence; requests held during it must be ignored.
  task automatic wait_init(input logic [31:0] wa);
    wr_valid = 1'b1; wr_addr = wa; wr_be = 4'hF; wr_wdata = 32'hFFFFFFFF;
    rd_valid = 1'b1; rd_addr = 32'h0;
    for (int k = 0; k <= 256; k++) begin
      @(negedge clk);
      check("init_busy_a", init_busy_a, (k < 256));
      check("init_busy_b", init_busy_b, (k < 256));
      check("init_ready_a", ready_a, (k >= 256));
      check("init_ready_b", ready_b, (k >= 256));
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    check("run_state_a", st_a, 1);
    for (int i = 0; i < 256; i++) model[i] = '0;
    running = 1;
  endtask

  // Scoreboard, RD_LAT=1 instance.
  always @(negedge clk) if (mon_en) begin
    if (rsp_v_a === 1'b1) begin
      if (exp_qa.size() == 0) check("rsp_a_unexpected", 1, 0);
      else begin
        e_a = exp_qa.pop_front(); d_a = due_qa.pop_front();
        check("rsp_a_cycle", cyc, d_a);
        check("rsp_a_data", rdata_a, e_a[31:0]);
        check("rsp_a_err", rd_err_a, e_a[32]);
        last_a = e_a[31:0];
      end
    end else begin
      check("idle_a_err", rd_err_a, 0);
      check("idle_a_hold", rdata_a, last_a);
      if (exp_qa.size() > 0 && due_qa[0] < cyc) begin
        check("rsp_a_missing", 0, 1);
        void'(exp_qa.pop_front()); void'(due_qa.pop_front());
      end
    end
  end

  // Scoreboard, RD_LAT=2 instance.
  always @(negedge clk) if (mon_en) begin
    if (rsp_v_b === 1'b1) begin
      if (exp_qb.size() == 0) check("rsp_b_unexpected", 1, 0);
      else begin
        e_b = exp_qb.pop_front(); d_b = due_qb.pop_front();
        check("rsp_b_cycle", cyc, d_b);
        check("rsp_b_data", rdata_b, e_b[31:0]);
        check("rsp_b_err", rd_err_b, e_b[32]);
        last_b = e_b[31:0];
      end
    end else begin
      check("idle_b_err", rd_err_b, 0);
      check("idle_b_hold", rdata_b, last_b);
      if (exp_qb.size() > 0 && due_qb[0] < cyc) begin
        check("rsp_b_missing", 0, 1);
        void'(exp_qb.pop_front()); void'(due_qb.pop_front());
      end
    end
  end

  // Write-error pulse checker for both instances.
  always @(negedge clk) if (mon_en) begin
    bit e;
    while (werr_q.size() > 0 && werr_q[0] < cyc) void'(werr_q.pop_front());
    e = (werr_q.size() > 0 && werr_q[0] == cyc);
    if (e) void'(werr_q.pop_front());
    check("wr_err_a", wr_err_a, e);
    check("wr_err_b", wr_err_b, e);
  end

  // Watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] col_exp;
    logic [32:0] x0, x1, x2;
    rst = 1'b1;
    wr_valid = 1'b0; rd_valid = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_be = '0; wr_wdata = '0;
    last_a = '0; last_b = '0;
    @(posedge clk);
    do_reset(0);
    wait_init(32'h0);

`ifdef DMEM_CTRL_BYPASS_EN
    col_exp = {1'b0, 32'h11112222};
`else
    col_exp = {1'b0, 32'h11111111};
`endif
    //              w  wa            be    wd            r  ra            exp
    tbl.push_back('{0, 32'h0,        4'h0, 32'h0,        1, 32'h3FC,      {1'b0, 32'h00000000}});
    tbl.push_back('{1, 32'h3FC,      4'h5, 32'hAABBCCDD, 0, 32'h0,        {1'b0, 32'h0}});
    tbl.push_back('{0, 32'h0,        4'h0, 32'h0,        1, 32'h3FC,      {1'b0, 32'h00BB00DD}});
    tbl.push_back('{1, 32'h400,      4'hF, 32'hFFFFFFFF, 0, 32'h0,        {1'b0, 32'h0}});
    tbl.push_back('{0, 32'h0,        4'h0, 32'h0,        1, 32'h400,      {1'b1, 32'h00000000}});
    tbl.push_back('{0, 32'h0,        4'h0, 32'h0,        1, 32'h000,      {1'b0, 32'h00000000}});
    tbl.push_back('{1, 32'h10,       4'hF, 32'h11111111, 0, 32'h0,        {1'b0, 32'h0}});
    tbl.push_back('{1, 32'h10,       4'h3, 32'h22222222, 1, 32'h10,       col_exp});
    tbl.push_back('{0, 32'h0,        4'h0, 32'h0,        1, 32'h10,       {1'b0, 32'h11112222}});
    tbl.push_back('{1, 32'h20,       4'h0, 32'hFFFFFFFF, 1, 32'h20,       {1'b0, 32'h00000000}});
    tbl.push_back('{0, 32'h0,        4'h0, 32'h0,        1, 32'h20,       {1'b0, 32'h00000000}});
    tbl.push_back('{0, 32'h0,        4'h0, 32'h0,        1, 32'h3FF,      {1'b0, 32'h00BB00DD}});
    tbl.push_back('{0, 32'h0,        4'h0, 32'h0,        1, 32'hFFFFFFFC, {1'b1, 32'h00000000}});
    tbl.push_back('{1, 32'h80000010, 4'hF, 32'h12345678, 1, 32'h10,       {1'b0, 32'h11112222}});
    tbl.push_back('{1, 32'h44,       4'hF, 32'h12345678, 1, 32'h3FC,      {1'b0, 32'h00BB00DD}});
    tbl.push_back('{0, 32'h0,        4'h0, 32'h0,        1, 32'h44,       {1'b0, 32'h12345678}});
    tbl.push_back('{1, 32'h3FC,      4'hA, 32'h11223344, 0, 32'h0,        {1'b0, 32'h0}});
    tbl.push_back('{0, 32'h0,        4'h0, 32'h0,        1, 32'h3FC,      {1'b0, 32'h11BB33DD}});
    tbl.push_back('{0, 32'h0,        4'h0, 32'h0,        1, 32'h10,       {1'b0, 32'h11112222}});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].w, tbl[i].wa, tbl[i].be, tbl[i].wd, tbl[i].r, tbl[i].ra, tbl[i].exp);
    end
    idle(4);

    // Random traffic over a small window so collisions are frequent.
    for (int i = 0; i < 300; i++) begin
      bit          w, r;
      logic [31:0] wa, ra, wd;
      logic [3:0]  be;
      w  = 1'($urandom_range(0, 1));
      r  = 1'($urandom_range(0, 1));
      wa = 32'($urandom_range(0, 7)) << 2 | 32'($urandom_range(0, 3));
      ra = 32'($urandom_range(0, 7)) << 2 | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) wa = wa | (32'h1 << $urandom_range(10, 31));
      if ($urandom_range(0, 15) == 0) ra = ra | (32'h1 << $urandom_range(10, 31));
      be = 4'($urandom_range(0, 15));
      wd = $urandom;
      drive(w, wa, be, wd, r, ra, model_expect(ra, w, wa, be, wd));
    end
    idle(4);

    // Three back-to-back reads, then reset while the RD_LAT=2 instance is
    // presenting its second response: the third must never appear.
    x0 = model_expect(32'h0, 0, 0, 0, 0);
    x1 = model_expect(32'h4, 0, 0, 0, 0);
    x2 = model_expect(32'h8, 0, 0, 0, 0);
    drive(0, 32'h0, 4'h0, 32'h0, 1, 32'h0, x0);
    drive(0, 32'h0, 4'h0, 32'h0, 1, 32'h4, x1);
    drive(0, 32'h0, 4'h0, 32'h0, 1, 32'h8, x2);
    do_reset(1);
    wait_init(32'h400);

    // Reset in the middle of INIT restarts the full clear.
    do_reset(0);
    idle(50);
    do_reset(0);
    wait_init(32'h3FC);

    // Contents written before the resets are gone.
    drive(0, 32'h0, 4'h0, 32'h0, 1, 32'h3FC, {1'b0, 32'h0});
    drive(0, 32'h0, 4'h0, 32'h0, 1, 32'h10,  {1'b0, 32'h0});
    drive(0, 32'h0, 4'h0, 32'h0, 1, 32'h44,  {1'b0, 32'h0});
    idle(6);
    check("end_queue_a", exp_qa.size(), 0);
    check("end_queue_b", exp_qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
